// File: rtl/prog_loader_if.sv
// Program-loader bus bundle: instruction stream in, InstROM write port out,
// and the core Start/Ack pair. The loader uses the slave view; the stream
// source / core side uses the master view.
interface prog_loader_if #(
  parameter int W = 9,
  parameter int A = 10
);
  logic         InValid;
  logic [W-1:0] InData;
  logic         InReady;
  logic         ImemWrEn;
  logic [A-1:0] ImemAddr;
  logic [W-1:0] ImemData;
  logic         CoreStart;
  logic         CoreAck;

  modport master (
    output InValid, InData, CoreAck,
    input  InReady, ImemWrEn, ImemAddr, ImemData, CoreStart
  );

  modport slave (
    input  InValid, InData, CoreAck,
    output InReady, ImemWrEn, ImemAddr, ImemData, CoreStart
  );
endinterface

// File: rtl/prog_loader.sv
// Upstream sequencer for the 9-bit core: streams a program into the
// instruction memory from address 0, pulses the core Start, waits for Ack,
// and counts run cycles. Error is sticky until the next legal load/rerun.
module prog_loader #(
  parameter int          W         = 9,
  parameter int          A         = 10,
  parameter int          START_CYC = 2,
  parameter logic [15:0] MAX_CYC   = 16'hFFFF
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          LoadReq,
  input  logic [A:0]    LoadLen,
  input  logic          Rerun,
  prog_loader_if.slave  Bus,
  output logic          Busy,
  output logic          Done,
  output logic          Error,
  output logic [15:0]   CycleCount
);

  localparam int          SW         = (START_CYC > 1) ? $clog2(START_CYC) : 1;
  localparam logic [SW-1:0] START_LAST = SW'(START_CYC - 1);
  localparam logic [A:0]  MEM_DEPTH  = {1'b1, {A{1'b0}}};
  localparam logic [A:0]  LEN_ONE    = (A+1)'(1);

  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DONE} state_t;

  state_t        state, nextState;
  logic [A:0]    len;
  logic [A-1:0]  wrPtr;
  logic [SW-1:0] startCnt;
  logic [15:0]   cycCnt;
  logic          errReg;

  logic          lenLegal;
  logic          accept;
  logic          lastAccept;
  logic          startLast;
  logic [15:0]   cycNext;
  logic          timeout;

  assign lenLegal   = (LoadLen != '0) && (LoadLen <= MEM_DEPTH);
  assign accept     = Bus.InValid && (state == LOAD);
  // Len=2**A fits because the compare is done at A+1 bits; wrPtr then wraps unused.
  assign lastAccept = accept && ({1'b0, wrPtr} == (len - LEN_ONE));
  assign startLast  = (startCnt == START_LAST);
  assign cycNext    = cycCnt + 16'd1;
  assign timeout    = (cycNext == MAX_CYC);

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state decision
  always_comb begin
    nextState = state;
    case (state)
      IDLE:  if (LoadReq && lenLegal) nextState = LOAD;
      LOAD:  if (lastAccept) nextState = START;
      START: if (startLast) nextState = RUN;
      RUN:   if (Bus.CoreAck || timeout) nextState = DONE;
      DONE: begin
        // LoadReq has priority over Rerun even when its length is illegal.
        if (LoadReq) begin
          if (lenLegal) nextState = LOAD;
        end else if (Rerun) begin
          nextState = START;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Length latch, write pointer, start/run counters and sticky error
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      len      <= '0;
      wrPtr    <= '0;
      startCnt <= '0;
      cycCnt   <= '0;
      errReg   <= 1'b0;
    end else begin
      startCnt <= '0;
      case (state)
        IDLE, DONE: begin
          if (LoadReq) begin
            if (lenLegal) begin
              len    <= LoadLen;
              wrPtr  <= '0;
              errReg <= 1'b0;
            end else begin
              errReg <= 1'b1;
            end
          end else if (Rerun && (state == DONE)) begin
            errReg <= 1'b0;
          end
        end
        LOAD: if (accept) wrPtr <= wrPtr + A'(1);
        START: begin
          startCnt <= startCnt + SW'(1);
          cycCnt   <= '0;
        end
        RUN: begin
          cycCnt <= cycNext;
          if (timeout) errReg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Output decode from state and counters
  always_comb begin
    Bus.InReady   = 1'b0;
    Bus.ImemWrEn  = 1'b0;
    Bus.ImemAddr  = '0;
    Bus.ImemData  = '0;
    Bus.CoreStart = 1'b0;
    Busy          = 1'b0;
    Done          = 1'b0;
    case (state)
      LOAD: begin
        Bus.InReady  = 1'b1;
        Bus.ImemWrEn = accept;
        Bus.ImemAddr = wrPtr;
        Bus.ImemData = Bus.InData;
        Busy         = 1'b1;
      end
      START: begin
        Bus.CoreStart = 1'b1;
        Busy          = 1'b1;
      end
      RUN:  Busy = 1'b1;
      DONE: Done = 1'b1;
      default: ;
    endcase
    Error      = errReg;
    CycleCount = cycCnt;
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: hand sequences for reset and IDLE corner cases,
// then a table of load/rerun operations (fixed plus $urandom-generated)
// checked against expectations computed from the loader's rules.
module tb_prog_loader;

  localparam int W    = 9;
  localparam int A    = 10;
  localparam int MAXC = 20;
  localparam int DEPTH = 1 << A;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          LoadReq = 1'b0;
  logic [A:0]    LoadLen = '0;
  logic          Rerun = 1'b0;
  logic          Busy, Done, Error;
  logic [15:0]   CycleCount;

  prog_loader_if #(.W(W), .A(A)) bus();

  prog_loader #(.W(W), .A(A), .START_CYC(2), .MAX_CYC(16'd20)) dut (
    .Clk(Clk), .Reset(Reset), .LoadReq(LoadReq), .LoadLen(LoadLen), .Rerun(Rerun),
    .Bus(bus), .Busy(Busy), .Done(Done), .Error(Error), .CycleCount(CycleCount)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  // captured DUT writes and bench-side expected program image
  logic [W-1:0] dutMem [0:DEPTH-1];
  logic [W-1:0] expMem [0:DEPTH-1];
  int wrCount = 0;

  always @(negedge Clk) begin
    if (bus.ImemWrEn === 1'b1) begin
      dutMem[bus.ImemAddr] = bus.ImemData;
      wrCount = wrCount + 1;
    end
  end

  typedef struct {
    int op;          // 0 = LoadReq, 1 = Rerun
    int len;
    int ackDly;      // RUN cycle carrying Ack, 0 = never
    bit ackInStart;
    bit alsoRerun;
    bit specWords;
    bit expErr;
    int expCnt;
  } vec_t;

  vec_t vecs[$];
  bit   inDone = 0;
  int   lastCnt = 0;
  logic [W-1:0] specW [0:3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic bit legalLen(input int l);
    return (l >= 1) && (l <= DEPTH);
  endfunction

  function automatic vec_t mk(input int op, input int len, input int dly,
                              input bit ais, input bit rr, input bit sw);
    vec_t v;
    v.op = op; v.len = len; v.ackDly = dly;
    v.ackInStart = ais; v.alsoRerun = rr; v.specWords = sw;
    if (dly > 0 && dly < MAXC) begin
      v.expCnt = dly; v.expErr = 0;
    end else begin
      v.expCnt = MAXC; v.expErr = 1;
    end
    return v;
  endfunction

  task automatic runVec(input vec_t v);
    int w0, nStart, k, bad;
    bit fin;
    logic [W-1:0] word;
    if (v.op == 0) begin
      LoadReq = 1'b1; LoadLen = v.len[A:0]; Rerun = v.alsoRerun;
      tick();
      LoadReq = 1'b0; Rerun = 1'b0;
      if (!legalLen(v.len)) begin
        chk("illegal_err", Error, 1);
        chk("illegal_inready", bus.InReady, 0);
        chk("illegal_done", Done, inDone);
        chk("illegal_cnt", CycleCount, lastCnt);
        return;
      end
      chk("load_inready", bus.InReady, 1);
      chk("load_err_clr", Error, 0);
      chk("load_done_clr", Done, 0);
      w0 = wrCount;
      for (int i = 0; i < v.len; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.InValid = 1'b0; bus.InData = W'($urandom);
          #1 chk("gap_nowrite", bus.ImemWrEn, 0);
          tick();
        end
        word = v.specWords ? specW[i] : W'($urandom);
        expMem[i] = word;
        bus.InValid = 1'b1; bus.InData = word;
        #1;
        chk("wr_en", bus.ImemWrEn, 1);
        chk("wr_addr", bus.ImemAddr, i);
        tick();
      end
      bus.InValid = 1'b0;
      chk("wr_count", wrCount - w0, v.len);
      bad = 0;
      for (int i = 0; i < v.len; i++) if (dutMem[i] !== expMem[i]) bad++;
      chk("mem_data_bad", bad, 0);
    end else begin
      Rerun = 1'b1;
      tick();
      Rerun = 1'b0;
      chk("rerun_err_clr", Error, 0);
      chk("rerun_done_clr", Done, 0);
    end
    nStart = 0;
    while (bus.CoreStart === 1'b1 && nStart < 10) begin
      bus.CoreAck = v.ackInStart;
      tick();
      nStart++;
    end
    chk("start_cycles", nStart, 2);
    chk("run_busy", Busy, 1);
    k = 1; fin = 0;
    while (!fin && k <= 100) begin
      bus.CoreAck = (k == v.ackDly);
      tick();
      bus.CoreAck = 1'b0;
      if (Done === 1'b1) fin = 1;
      else k++;
    end
    chk("run_to_done_cycles", k, v.expCnt);
    chk("done", Done, 1);
    chk("cycle_count", CycleCount, v.expCnt);
    chk("run_err", Error, v.expErr);
    chk("done_not_busy", Busy, 0);
    inDone = 1;
    lastCnt = v.expCnt;
  endtask

  initial begin
    int w0, r, l;
    specW[0] = 9'h1A3; specW[1] = 9'h055; specW[2] = 9'h100; specW[3] = 9'h1FF;
    bus.InValid = 1'b0; bus.InData = '0; bus.CoreAck = 1'b0;

    // reset state
    #2;
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_err", Error, 0);
    chk("rst_cnt", CycleCount, 0);
    chk("rst_inready", bus.InReady, 0);
    chk("rst_start", bus.CoreStart, 0);
    tick(); tick();
    Reset = 1'b1;
    tick();

    // reset mid-load after 3 words
    LoadReq = 1'b1; LoadLen = 11'd8;
    tick();
    LoadReq = 1'b0;
    w0 = wrCount;
    for (int i = 0; i < 3; i++) begin
      bus.InValid = 1'b1; bus.InData = W'($urandom);
      tick();
    end
    Reset = 1'b0;
    #1;
    chk("midrst_inready", bus.InReady, 0);
    chk("midrst_wren", bus.ImemWrEn, 0);
    chk("midrst_addr", bus.ImemAddr, 0);
    chk("midrst_data", bus.ImemData, 0);
    chk("midrst_busy", Busy, 0);
    chk("midrst_start", bus.CoreStart, 0);
    tick();
    chk("midrst_writes", wrCount - w0, 3);
    bus.InValid = 1'b0; Reset = 1'b1;
    tick();
    chk("post_rst_idle", Busy, 0);

    // Rerun in IDLE is ignored
    Rerun = 1'b1;
    tick();
    Rerun = 1'b0;
    chk("idle_rerun_busy", Busy, 0);
    chk("idle_rerun_start", bus.CoreStart, 0);

    // fixed vectors
    vecs.push_back(mk(0, 0,    0,  0, 0, 0));  // illegal in IDLE
    vecs.push_back(mk(0, 1,    3,  0, 0, 0));  // legal after error
    vecs.push_back(mk(0, 4,    10, 0, 1, 1));  // spec words, LoadReq beats Rerun
    vecs.push_back(mk(0, 1025, 0,  0, 0, 0));  // illegal in DONE
    vecs.push_back(mk(1, 0,    0,  0, 0, 0));  // timeout
    vecs.push_back(mk(1, 0,    20, 0, 0, 0));  // Ack on the timeout cycle
    vecs.push_back(mk(1, 0,    19, 0, 0, 0));  // Ack just before timeout
    vecs.push_back(mk(0, 1024, 1,  1, 0, 0));  // full memory, Ack during START
    // randomized vectors
    for (int n = 0; n < 12; n++) begin
      r = $urandom_range(0, 5);
      if (r <= 2)      l = $urandom_range(1, 24);
      else if (r == 5) l = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1025, 2047);
      else             l = 0;
      vecs.push_back(mk((r == 3 || r == 4) ? 1 : 0, l, $urandom_range(0, 22),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0));
    end

    foreach (vecs[i]) runVec(vecs[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

endmodule
